fastica_iter_scheduler: RTL and testbench
=========================================

// Module: fastica_iter_scheduler
// PURPOSE
//  Sequences the FastICA one-unit datapath across iterations and components. Each iteration:
//   - launches the one-unit fast controller by holding go_fast high;
//   - detects completion of its MUL/MEAN/SUB pass from fast_busy;
//   - runs Gram-Schmidt decorrelation (skipped for component 0), then normalisation;
//   - checks convergence.
//  Steps through N_COMP components, then pulses done. Sits between the top-level host FSM and the one-unit datapath.
// PARAMETERS
//  N_COMP      4    number of independent components to extract (>=1)
//  MAX_ITER    16   iteration cap per component (>=1)
//  CW          2    comp_idx width, clog2(N_COMP) (min 1)
//  IW          5    iter_cnt width, clog2(MAX_ITER)+1
//  WDOG_CYCLES 255  RUN-state cycle limit (used only with ICA_WDOG_EN)
// PORTS
//  clk_fast     in   1   single clock; all flops posedge
//  rst_fast     in   1   asynchronous, active-high reset
//  start        in   1   1-cycle request; accepted only in IDLE
//  abort        in   1   synchronous abort; any state -> IDLE next cycle
//  go_fast      out  1   unit run/hold; low holds one-unit controller in INIT
//  fast_busy    in   1   busy flag from one-unit controller
//  en_decor     out  1   decorrelation enable, level, DECOR state
//  decor_done   in   1   1-cycle completion from decorrelator
//  en_norm      out  1   normaliser enable, level, NORM state
//  norm_done    in   1   1-cycle completion from normaliser
//  conv_valid   in   1   convergence result valid (sampled in CHECK)
//  conv_ok      in   1   |w_new.w_old| within tolerance; qualified by conv_valid
//  en_wstore    out  1   1-cycle pulse: commit w to weight RAM at comp_idx
//  comp_idx     out  CW  current component
//  iter_cnt     out  IW  iterations completed for current component
//  busy         out  1   high in every state except IDLE
//  done         out  1   1-cycle pulse after last component stored
//  not_conv     out  1   sticky: some component hit MAX_ITER without conv_ok; cleared on accepted start
//  err_wdog     out  1   sticky watchdog error (tied 0 without ICA_WDOG_EN); cleared on accepted start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, comp_idx, iter_cnt, seen_busy and flags = 0. go_fast=0 also resets the unit.
//  Enables/done/en_wstore decode from the state register (Moore). No combinational input->output paths.
//  IDLE:   start=1 -> RUN; clear comp_idx, iter_cnt, not_conv, err_wdog.
//  RUN:    go_fast=1; seen_busy<=1 when fast_busy=1. seen_busy && !fast_busy -> DECOR if comp_idx!=0, else NORM.
//          Clear seen_busy on exit. go_fast falls on the cycle after completion detect, returning the unit to INIT.
//  DECOR:  en_decor=1 until decor_done -> NORM.
//  NORM:   en_norm=1 until norm_done -> CHECK.
//  CHECK:  wait for conv_valid.
//          conv_ok=1 -> STORE.
//          conv_ok=0 && iter_cnt==MAX_ITER-1 -> STORE, set not_conv.
//          Otherwise iter_cnt++ -> RUN.
//  STORE:  en_wstore=1 for exactly 1 cycle.
//          comp_idx==N_COMP-1 -> FINISH.
//          Otherwise comp_idx++, iter_cnt=0 -> RUN.
//  FINISH: done=1 for 1 cycle -> IDLE. comp_idx and iter_cnt hold their values until the next start.
//  abort:  highest priority after reset. Next state = IDLE, go_fast=0 the next cycle. No done, no en_wstore.
//          Flags are kept; counters hold.
//  start while busy: ignored. start and abort in the same cycle in IDLE: abort wins, stay IDLE.
//  done-pulse inputs (decor_done, norm_done, conv_valid) outside their state are ignored.
//  Counters never wrap: iter_cnt <= MAX_ITER-1 and comp_idx <= N_COMP-1 by construction.
//  fast_busy never rising in RUN: the block waits indefinitely (watchdog only).
// CONFIGURATION
//  ICA_WDOG_EN defined:
//    - RUN cycle counter clears on RUN entry.
//    - When it reaches WDOG_CYCLES: set err_wdog, -> IDLE, go_fast=0, no done.
//  ICA_WDOG_EN undefined: no counter; err_wdog tied 0; RUN waits unbounded.
// STRUCTURE
//  Shared package fastica_pkg: state encoding localparams (IDLE, RUN, DECOR, NORM, CHECK, STORE, FINISH),
//  default N_COMP/MAX_ITER constants.
//  Single module. The watchdog counter stays inline (too small for a sub-module).
// TESTING
//  1 Reset mid-RUN: rst_fast=1 -> all outputs 0 the same cycle (async), state IDLE, go_fast=0.
//  2 N_COMP=2, unit model busy 133 cycles, conv_ok=1 first check:
//    - comp0 skips DECOR; comp1 asserts en_decor;
//    - exactly 2 en_wstore pulses, comp_idx 0 then 1;
//    - done pulses once; not_conv=0.
//  3 MAX_ITER=4, conv_ok always 0:
//    - go_fast rises 4 times per component; iter_cnt reaches 3;
//    - STORE still occurs; not_conv=1 after done.
//  4 abort asserted in NORM of comp 1 -> IDLE next cycle, no done/en_wstore; a new start clears not_conv and comp_idx=0.
//  5 start pulsed in CHECK, plus stray norm_done in RUN -> both ignored; sequence and counts unchanged.
//  6 ICA_WDOG_EN, WDOG_CYCLES=20, fast_busy held 0 -> err_wdog=1 after 20 RUN cycles, go_fast=0, IDLE, no done.

Source files
------------

// File: rtl/fastica_iter_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// fastica_pkg
//   Shared definitions for the FastICA iteration scheduler:
//   - default component count and iteration cap
//   - scheduler state encoding
//   - state_outputs(): Moore decode of a state into the five control strobes
// ----------------------------------------------------------------------------
package fastica_pkg;

  localparam int N_COMP_DEF   = 4;
  localparam int MAX_ITER_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DECOR  = 3'd2,
    ST_NORM   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_STORE  = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  // Returns {go_fast, en_decor, en_norm, en_wstore, done} for a state.
  function automatic logic [4:0] state_outputs(input state_t s);
    logic [4:0] v;
    v = 5'b00000;
    case (s)
      ST_RUN:    v = 5'b10000;
      ST_DECOR:  v = 5'b01000;
      ST_NORM:   v = 5'b00100;
      ST_STORE:  v = 5'b00010;
      ST_FINISH: v = 5'b00001;
      default:   v = 5'b00000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fastica_iter_scheduler.sv
// ----------------------------------------------------------------------------
// fastica_iter_scheduler
//   Sequences the FastICA one-unit datapath over iterations and components:
//   RUN (one-unit pass) -> DECOR (skipped for component 0) -> NORM -> CHECK,
//   repeating until convergence or the iteration cap, then STORE. After the
//   last component, FINISH pulses done.
//
//   Optional feature: define ICA_WDOG_EN to add a RUN-state watchdog. After
//   WDOG_CYCLES cycles in RUN it sets err_wdog and returns to IDLE. Without
//   the macro err_wdog is constant 0 and RUN waits indefinitely.
//
// Ports
//   clk_fast, rst_fast : clock, asynchronous active-high reset
//   start, abort       : host request (accepted in IDLE) / synchronous abort
//   go_fast, fast_busy : one-unit run/hold and its busy flag
//   en_decor/decor_done, en_norm/norm_done : stage enable / completion
//   conv_valid, conv_ok: convergence result, sampled in CHECK
//   en_wstore          : 1-cycle weight commit strobe at comp_idx
//   comp_idx, iter_cnt : current component / iterations completed
//   busy, done         : not IDLE / 1-cycle completion pulse
//   not_conv, err_wdog : sticky flags, cleared on an accepted start
// ----------------------------------------------------------------------------
module fastica_iter_scheduler
  import fastica_pkg::*;
#(
  parameter int N_COMP      = N_COMP_DEF,
  parameter int MAX_ITER    = MAX_ITER_DEF,
  parameter int CW          = 2,
  parameter int IW          = 5,
  parameter int WDOG_CYCLES = 255
) (
  input  logic          clk_fast,
  input  logic          rst_fast,
  input  logic          start,
  input  logic          abort,
  output logic          go_fast,
  input  logic          fast_busy,
  output logic          en_decor,
  input  logic          decor_done,
  output logic          en_norm,
  input  logic          norm_done,
  input  logic          conv_valid,
  input  logic          conv_ok,
  output logic          en_wstore,
  output logic [CW-1:0] comp_idx,
  output logic [IW-1:0] iter_cnt,
  output logic          busy,
  output logic          done,
  output logic          not_conv,
  output logic          err_wdog
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_comp_idx;
  logic [IW-1:0] r_iter_cnt;
  logic          r_seen_busy;
  logic          r_go_fast, r_en_decor, r_en_norm, r_en_wstore, r_done, r_busy;
  logic          r_not_conv, r_err_wdog;
  logic          w_wdog_trip;
  logic          w_accept;
  logic          w_last_comp;
  logic          w_last_iter;

  assign w_accept    = (r_state == ST_IDLE) && start && !abort;
  assign w_last_comp = (r_comp_idx == CW'(N_COMP - 1));
  assign w_last_iter = (r_iter_cnt == IW'(MAX_ITER - 1));

`ifdef ICA_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] r_wdog_cnt;

  assign w_wdog_trip = (r_state == ST_RUN) && (r_wdog_cnt == WW'(WDOG_CYCLES - 1));

  // RUN cycle counter; held at zero outside RUN so every RUN entry starts fresh
  always_ff @(posedge clk_fast or posedge rst_fast) begin
    if (rst_fast) begin
      r_wdog_cnt <= '0;
    end else if (r_state != ST_RUN) begin
      r_wdog_cnt <= '0;
    end else if (!w_wdog_trip) begin
      r_wdog_cnt <= r_wdog_cnt + WW'(1);
    end
  end
`else
  // No watchdog: never trips (WDOG_CYCLES is kept only for a uniform interface)
  assign w_wdog_trip = (WDOG_CYCLES < 0);
`endif

  // Next-state logic; abort overrides every state
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) w_state_nxt = ST_RUN;
          else       w_state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          if (w_wdog_trip)                    w_state_nxt = ST_IDLE;
          else if (r_seen_busy && !fast_busy) w_state_nxt = (r_comp_idx != '0) ? ST_DECOR : ST_NORM;
          else                                w_state_nxt = ST_RUN;
        end
        ST_DECOR: begin
          if (decor_done) w_state_nxt = ST_NORM;
          else            w_state_nxt = ST_DECOR;
        end
        ST_NORM: begin
          if (norm_done) w_state_nxt = ST_CHECK;
          else           w_state_nxt = ST_NORM;
        end
        ST_CHECK: begin
          if (conv_valid && (conv_ok || w_last_iter)) w_state_nxt = ST_STORE;
          else if (conv_valid)                        w_state_nxt = ST_RUN;
          else                                        w_state_nxt = ST_CHECK;
        end
        ST_STORE: begin
          if (w_last_comp) w_state_nxt = ST_FINISH;
          else             w_state_nxt = ST_RUN;
        end
        ST_FINISH: w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, registered Moore strobes, counters and sticky flags
  always_ff @(posedge clk_fast or posedge rst_fast) begin
    if (rst_fast) begin
      r_state     <= ST_IDLE;
      r_go_fast   <= 1'b0;
      r_en_decor  <= 1'b0;
      r_en_norm   <= 1'b0;
      r_en_wstore <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_comp_idx  <= '0;
      r_iter_cnt  <= '0;
      r_seen_busy <= 1'b0;
      r_not_conv  <= 1'b0;
      r_err_wdog  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Strobes are decoded from the next state so they line up with r_state
      {r_go_fast, r_en_decor, r_en_norm, r_en_wstore, r_done} <= state_outputs(w_state_nxt);
      r_busy <= (w_state_nxt != ST_IDLE);
      // seen_busy only lives while staying in RUN; any exit clears it
      r_seen_busy <= (w_state_nxt == ST_RUN) &&
                     (r_seen_busy || ((r_state == ST_RUN) && fast_busy));
      if (w_accept) begin
        r_comp_idx <= '0;
        r_iter_cnt <= '0;
        r_not_conv <= 1'b0;
        r_err_wdog <= 1'b0;
      end else if (!abort) begin
        if (w_wdog_trip) r_err_wdog <= 1'b1;
        if ((r_state == ST_CHECK) && conv_valid && !conv_ok) begin
          if (w_last_iter) r_not_conv <= 1'b1;
          else             r_iter_cnt <= r_iter_cnt + IW'(1);
        end
        if ((r_state == ST_STORE) && !w_last_comp) begin
          r_comp_idx <= r_comp_idx + CW'(1);
          r_iter_cnt <= '0;
        end
      end
    end
  end

  assign go_fast   = r_go_fast;
  assign en_decor  = r_en_decor;
  assign en_norm   = r_en_norm;
  assign en_wstore = r_en_wstore;
  assign done      = r_done;
  assign busy      = r_busy;
  assign comp_idx  = r_comp_idx;
  assign iter_cnt  = r_iter_cnt;
  assign not_conv  = r_not_conv;
  assign err_wdog  = r_err_wdog;

endmodule

// File: tb/tb_fastica_iter_scheduler.sv
// ----------------------------------------------------------------------------
// tb_fastica_iter_scheduler
//   Directed bench for fastica_iter_scheduler with N_COMP=2, MAX_ITER=4.
//   A procedural responder plays the one-unit controller, decorrelator,
//   normaliser and convergence checker; a vector table selects convergence
//   behaviour per job and holds the hand-computed expected counts.
//   The watchdog sequence runs only when ICA_WDOG_EN is defined.
// ----------------------------------------------------------------------------
module tb_fastica_iter_scheduler;

  logic       clk_fast = 1'b0;
  logic       rst_fast = 1'b1;
  logic       start = 1'b0, abort = 1'b0, fast_busy = 1'b0;
  logic       decor_done = 1'b0, norm_done = 1'b0, conv_valid = 1'b0, conv_ok = 1'b0;
  logic       go_fast, en_decor, en_norm, en_wstore, busy, done, not_conv, err_wdog;
  logic [0:0] comp_idx;
  logic [2:0] iter_cnt;

`ifdef ICA_WDOG_EN
  localparam int BUSY_LONG = 10;
`else
  localparam int BUSY_LONG = 133;
`endif

  fastica_iter_scheduler #(
    .N_COMP(2), .MAX_ITER(4), .CW(1), .IW(3), .WDOG_CYCLES(20)
  ) dut (
    .clk_fast(clk_fast), .rst_fast(rst_fast), .start(start), .abort(abort),
    .go_fast(go_fast), .fast_busy(fast_busy), .en_decor(en_decor),
    .decor_done(decor_done), .en_norm(en_norm), .norm_done(norm_done),
    .conv_valid(conv_valid), .conv_ok(conv_ok), .en_wstore(en_wstore),
    .comp_idx(comp_idx), .iter_cnt(iter_cnt), .busy(busy), .done(done),
    .not_conv(not_conv), .err_wdog(err_wdog)
  );

  always #5 clk_fast = ~clk_fast;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Per-job observations
  int go_rises, go_c0, decor_rises, decor_c0, wstore_cnt, done_cnt, max_iter;
  int ws_comp0, ws_comp1;
  bit timed_out;

  // conv_at: 0-based check index on which conv_ok is first given (99 = never)
  task automatic run_job(input int conv_at, input int busy_cyc, input bit stray, input bit abort_c1);
    int ucnt = 0, checks = 0, cyc = 0;
    bit prev_go = 1'b0, prev_dec = 1'b0, pend = 1'b0, fin = 1'b0;
    go_rises = 0; go_c0 = 0; decor_rises = 0; decor_c0 = 0; wstore_cnt = 0;
    done_cnt = 0; max_iter = 0; ws_comp0 = -1; ws_comp1 = -1; timed_out = 1'b0;
    @(negedge clk_fast);
    start = 1'b1;
    while (!fin) begin
      @(negedge clk_fast);
      start = 1'b0; abort = 1'b0; decor_done = 1'b0; norm_done = 1'b0;
      conv_valid = 1'b0; conv_ok = 1'b0;
      cyc++;
      if (go_fast && !prev_go) begin
        go_rises++;
        if (comp_idx == 1'b0) go_c0++;
      end
      if (en_decor && !prev_dec) begin
        decor_rises++;
        if (comp_idx == 1'b0) decor_c0++;
      end
      if (en_wstore) begin
        wstore_cnt++;
        if (wstore_cnt == 1) ws_comp0 = int'(comp_idx);
        if (wstore_cnt == 2) ws_comp1 = int'(comp_idx);
        checks = 0;
      end
      if (int'(iter_cnt) > max_iter) max_iter = int'(iter_cnt);
      if (done) begin
        done_cnt++;
        fin = 1'b1;
      end
      prev_go  = go_fast;
      prev_dec = en_decor;
      // One-unit controller: busy for busy_cyc cycles, starting one cycle after go
      if (go_fast) ucnt++;
      else         ucnt = 0;
      fast_busy = go_fast && (ucnt >= 2) && (ucnt <= busy_cyc + 1);
      if (stray && go_fast && ucnt == 3) norm_done = 1'b1;
      if (en_decor) decor_done = 1'b1;
      if (pend) begin
        conv_valid = 1'b1;
        conv_ok    = (checks >= conv_at);
        checks++;
        if (stray) start = 1'b1;
        pend = 1'b0;
      end
      if (en_norm && !(abort_c1 && comp_idx == 1'b1)) begin
        norm_done = 1'b1;
        pend = 1'b1;
      end
      if (abort_c1 && en_norm && comp_idx == 1'b1) begin
        abort = 1'b1;
        fin = 1'b1;
      end
      if (cyc >= 6000) begin
        timed_out = 1'b1;
        fin = 1'b1;
      end
    end
  endtask

  typedef struct {
    int conv_at;
    int busy_cyc;
    bit stray;
    int exp_go;
    int exp_decor;
    int exp_iter;
    int exp_nc;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{0,  BUSY_LONG, 1'b0, 2, 1, 0, 0};
    vecs[1] = '{99, 6,         1'b0, 8, 4, 3, 1};
    vecs[2] = '{2,  6,         1'b0, 6, 3, 2, 0};
    vecs[3] = '{1,  6,         1'b1, 4, 2, 1, 0};

    repeat (3) @(negedge clk_fast);
    chk("reset_outputs", int'({go_fast, en_decor, en_norm, en_wstore, busy, done,
                               not_conv, err_wdog, comp_idx, iter_cnt}), 0);
    rst_fast = 1'b0;
    @(negedge clk_fast);
    chk("idle_busy", int'(busy), 0);

    // Asynchronous reset in the middle of RUN
    start = 1'b1;
    @(negedge clk_fast);
    start = 1'b0;
    repeat (4) @(negedge clk_fast);
    chk("run_go_fast", int'(go_fast), 1);
    chk("run_busy", int'(busy), 1);
    #2 rst_fast = 1'b1;
    #1;
    chk("async_reset_outputs", int'({go_fast, en_decor, en_norm, en_wstore, busy, done,
                                     not_conv, err_wdog, comp_idx, iter_cnt}), 0);
    @(negedge clk_fast);
    rst_fast = 1'b0;
    @(negedge clk_fast);
    chk("after_reset_go", int'(go_fast), 0);

    // Full jobs from the vector table
    for (int i = 0; i < 4; i++) begin
      run_job(vecs[i].conv_at, vecs[i].busy_cyc, vecs[i].stray, 1'b0);
      chk($sformatf("v%0d_timeout", i), int'(timed_out), 0);
      chk($sformatf("v%0d_go_rises", i), go_rises, vecs[i].exp_go);
      chk($sformatf("v%0d_go_rises_c0", i), go_c0, vecs[i].exp_go / 2);
      chk($sformatf("v%0d_decor_rises", i), decor_rises, vecs[i].exp_decor);
      chk($sformatf("v%0d_decor_c0", i), decor_c0, 0);
      chk($sformatf("v%0d_wstore_cnt", i), wstore_cnt, 2);
      chk($sformatf("v%0d_wstore_comp0", i), ws_comp0, 0);
      chk($sformatf("v%0d_wstore_comp1", i), ws_comp1, 1);
      chk($sformatf("v%0d_max_iter", i), max_iter, vecs[i].exp_iter);
      chk($sformatf("v%0d_not_conv", i), int'(not_conv), vecs[i].exp_nc);
      @(negedge clk_fast);
      chk($sformatf("v%0d_done_single", i), int'(done), 0);
      chk($sformatf("v%0d_idle", i), int'(busy), 0);
      chk($sformatf("v%0d_comp_hold", i), int'(comp_idx), 1);
      chk($sformatf("v%0d_iter_hold", i), int'(iter_cnt), vecs[i].exp_iter);
    end

    // Abort in NORM of component 1 after component 0 failed to converge
    run_job(99, 6, 1'b0, 1'b1);
    chk("abort_reached", int'(timed_out), 0);
    @(negedge clk_fast);
    abort = 1'b0;
    chk("abort_idle", int'({busy, go_fast, en_norm}), 0);
    chk("abort_keeps_not_conv", int'(not_conv), 1);
    chk("abort_holds_comp", int'(comp_idx), 1);
    done_cnt = 0;
    wstore_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_fast);
      if (done) done_cnt++;
      if (en_wstore) wstore_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_wstore", wstore_cnt, 0);
    start = 1'b1;
    @(negedge clk_fast);
    start = 1'b0;
    chk("restart_not_conv", int'(not_conv), 0);
    chk("restart_comp", int'(comp_idx), 0);
    chk("restart_busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk_fast);
    abort = 1'b0;
    chk("abort_run", int'({busy, go_fast}), 0);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk_fast);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", int'({busy, go_fast}), 0);

`ifdef ICA_WDOG_EN
    // fast_busy never rises: watchdog trips after 20 RUN cycles
    fast_busy = 1'b0;
    start = 1'b1;
    @(negedge clk_fast);
    start = 1'b0;
    repeat (19) @(negedge clk_fast);
    chk("wdog_not_yet", int'({err_wdog, busy}), 1);
    @(negedge clk_fast);
    chk("wdog_err", int'(err_wdog), 1);
    chk("wdog_idle", int'({busy, go_fast, done}), 0);
    start = 1'b1;
    @(negedge clk_fast);
    start = 1'b0;
    chk("wdog_cleared", int'(err_wdog), 0);
    abort = 1'b1;
    @(negedge clk_fast);
    abort = 1'b0;
`else
    chk("err_wdog_tied", int'(err_wdog), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
